// File: rtl/hfrv_trace_capture_if.sv
// Bus bundle for hfrv_trace_capture: capture control, commit snoop, match config and pop/read side.
// The timestamp port exists only when HFRV_TRACE_TSTAMP_EN is defined.
interface hfrv_trace_capture_if #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 64,
    parameter int NUM_MATCH = 2
`ifdef HFRV_TRACE_TSTAMP_EN
    , parameter int TS_W    = 32
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                   arm_i;
    logic                   abort_i;
    logic                   commit_valid_i;
    logic [XLEN-1:0]        commit_pc_i;
    logic [31:0]            commit_instr_i;
    logic [NUM_MATCH-1:0]   match_en_i;
    logic [7*NUM_MATCH-1:0] match_opcode_i;
    logic                   rd_pop_i;
    logic                   rd_valid_o;
    logic [XLEN-1:0]        rd_pc_o;
    logic [31:0]            rd_instr_o;
    logic                   rd_last_o;
    logic [CW-1:0]          count_o;
    logic [1:0]             state_o;
    logic                   triggered_o;
`ifdef HFRV_TRACE_TSTAMP_EN
    logic [TS_W-1:0]        rd_tstamp_o;
`endif

    modport master (
`ifdef HFRV_TRACE_TSTAMP_EN
        input  rd_tstamp_o,
`endif
        output arm_i, abort_i, commit_valid_i, commit_pc_i, commit_instr_i,
        output match_en_i, match_opcode_i, rd_pop_i,
        input  rd_valid_o, rd_pc_o, rd_instr_o, rd_last_o, count_o, state_o, triggered_o
    );

    modport slave (
`ifdef HFRV_TRACE_TSTAMP_EN
        output rd_tstamp_o,
`endif
        input  arm_i, abort_i, commit_valid_i, commit_pc_i, commit_instr_i,
        input  match_en_i, match_opcode_i, rd_pop_i,
        output rd_valid_o, rd_pc_o, rd_instr_o, rd_last_o, count_o, state_o, triggered_o
    );
endinterface

// File: rtl/hfrv_trace_capture.sv
// Commit-stream trace buffer: circular capture, opcode trigger, post-trigger window, then oldest-first FWFT pop.
// Optional per-entry cycle timestamp when HFRV_TRACE_TSTAMP_EN is defined.
module hfrv_trace_capture #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 64,
    parameter int POST_TRIG = 16,
    parameter int NUM_MATCH = 2
`ifdef HFRV_TRACE_TSTAMP_EN
    , parameter int TS_W    = 32
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    hfrv_trace_capture_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state,    w_state_nxt;
    logic [AW-1:0]   r_wr_ptr,   w_wr_ptr_nxt;
    logic [CW-1:0]   r_count,    w_count_nxt;
    logic [AW-1:0]   r_post_cnt, w_post_nxt;
    logic            r_trig,     w_trig_nxt;
    logic            w_we;
    logic            w_opc_hit;
    logic            w_match;
    logic            w_capturing;
    logic            w_rd_valid;
    logic [AW-1:0]   w_head;

    logic [XLEN-1:0] r_pc_mem    [DEPTH];
    logic [31:0]     r_instr_mem [DEPTH];

    always_comb begin
        w_opc_hit = 1'b0;
        for (int k = 0; k < NUM_MATCH; k++) begin
            if (bus.match_en_i[k] && (bus.commit_instr_i[6:0] == bus.match_opcode_i[7*k +: 7]))
                w_opc_hit = 1'b1;
        end
    end

    assign w_match     = bus.commit_valid_i & w_opc_hit;
    assign w_capturing = (r_state == S_ARMED) || (r_state == S_POST);

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_count_nxt  = r_count;
        w_post_nxt   = r_post_cnt;
        w_trig_nxt   = r_trig;
        w_we         = 1'b0;

        // Abort outranks arm while capturing; a same-cycle commit still lands.
        if (bus.abort_i && w_capturing) begin
            w_we        = bus.commit_valid_i;
            w_state_nxt = S_DONE;
            if (r_state == S_ARMED && w_match)
                w_trig_nxt = 1'b1;
        end else if (bus.arm_i) begin
            w_state_nxt  = S_ARMED;
            w_wr_ptr_nxt = '0;
            w_count_nxt  = '0;
            w_post_nxt   = '0;
            w_trig_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_ARMED: begin
                    if (bus.commit_valid_i) begin
                        w_we = 1'b1;
                        if (w_match) begin
                            w_trig_nxt  = 1'b1;
                            w_post_nxt  = POST_INIT;
                            w_state_nxt = (POST_TRIG == 0) ? S_DONE : S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (bus.commit_valid_i) begin
                        w_we       = 1'b1;
                        w_post_nxt = r_post_cnt - AW'(1);
                        if (r_post_cnt == AW'(1))
                            w_state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.rd_pop_i && (r_count != '0))
                        w_count_nxt = r_count - CW'(1);
                end
                default: ;
            endcase
        end

        if (w_we) begin
            w_wr_ptr_nxt = r_wr_ptr + AW'(1);
            if (r_count != CW'(DEPTH))
                w_count_nxt = r_count + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_post_cnt <= '0;
            r_trig     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_count    <= w_count_nxt;
            r_post_cnt <= w_post_nxt;
            r_trig     <= w_trig_nxt;
        end
    end

    // Storage is never reset: a zero count already makes every slot invisible.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_pc_mem[r_wr_ptr]    <= bus.commit_pc_i;
            r_instr_mem[r_wr_ptr] <= bus.commit_instr_i;
        end
    end

    // Head is derived from the write pointer, so popping only shrinks the count.
    assign w_head     = r_wr_ptr - r_count[AW-1:0];
    assign w_rd_valid = (r_state == S_DONE) && (r_count != '0);

    assign bus.rd_valid_o  = w_rd_valid;
    assign bus.rd_pc_o     = w_rd_valid ? r_pc_mem[w_head] : '0;
    assign bus.rd_instr_o  = w_rd_valid ? r_instr_mem[w_head] : '0;
    assign bus.rd_last_o   = w_rd_valid && (r_count == CW'(1));
    assign bus.count_o     = r_count;
    assign bus.state_o     = r_state;
    assign bus.triggered_o = r_trig;

`ifdef HFRV_TRACE_TSTAMP_EN
    logic [TS_W-1:0] r_ts;
    logic [TS_W-1:0] r_ts_mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ts <= '0;
        else if (bus.arm_i)
            r_ts <= '0;
        else
            r_ts <= r_ts + TS_W'(1);
    end

    always_ff @(posedge clk) begin
        if (w_we)
            r_ts_mem[r_wr_ptr] <= r_ts;
    end

    assign bus.rd_tstamp_o = w_rd_valid ? r_ts_mem[w_head] : '0;
`endif
endmodule

// File: tb/tb_hfrv_trace_capture.sv
// Directed bench for hfrv_trace_capture: vector table plus hand sequences for trigger window, reset and timestamps.
module tb_hfrv_trace_capture;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] BEQ = 32'h0020_8463;
    localparam logic [31:0] LUI = 32'h0000_12b7;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        arm = 0, abort = 0, cv = 0, pop = 0;
    logic [31:0] pc = 0, instr = 0;
    logic [1:0]  men = 0;
    logic [13:0] mop = {7'h37, 7'h63};

`ifdef HFRV_TRACE_TSTAMP_EN
    hfrv_trace_capture_if #(.XLEN(32), .DEPTH(8), .NUM_MATCH(2), .TS_W(4)) ifa ();
    hfrv_trace_capture_if #(.XLEN(32), .DEPTH(8), .NUM_MATCH(2), .TS_W(4)) ifb ();
    hfrv_trace_capture #(.XLEN(32), .DEPTH(8), .POST_TRIG(2), .NUM_MATCH(2), .TS_W(4)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    hfrv_trace_capture #(.XLEN(32), .DEPTH(8), .POST_TRIG(0), .NUM_MATCH(2), .TS_W(4)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
`else
    hfrv_trace_capture_if #(.XLEN(32), .DEPTH(8), .NUM_MATCH(2)) ifa ();
    hfrv_trace_capture_if #(.XLEN(32), .DEPTH(8), .NUM_MATCH(2)) ifb ();
    hfrv_trace_capture #(.XLEN(32), .DEPTH(8), .POST_TRIG(2), .NUM_MATCH(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    hfrv_trace_capture #(.XLEN(32), .DEPTH(8), .POST_TRIG(0), .NUM_MATCH(2)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
`endif

    assign ifa.arm_i = arm;            assign ifb.arm_i = arm;
    assign ifa.abort_i = abort;        assign ifb.abort_i = abort;
    assign ifa.commit_valid_i = cv;    assign ifb.commit_valid_i = cv;
    assign ifa.commit_pc_i = pc;       assign ifb.commit_pc_i = pc;
    assign ifa.commit_instr_i = instr; assign ifb.commit_instr_i = instr;
    assign ifa.match_en_i = men;       assign ifb.match_en_i = men;
    assign ifa.match_opcode_i = mop;   assign ifb.match_opcode_i = mop;
    assign ifa.rd_pop_i = pop;         assign ifb.rd_pop_i = pop;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        arm, abort, cv, pop;
        logic [31:0] pc, instr;
        logic [1:0]  e_state;
        int          e_count;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_last, e_trig;
    } vec_t;
    vec_t vq[$];

    function automatic void add(input logic a, ab, c, pp, input logic [31:0] p, ins,
                                input logic [1:0] es, input int ec, input logic ev,
                                input logic [31:0] ep, input logic el, et);
        vec_t v;
        v.arm = a; v.abort = ab; v.cv = c; v.pop = pp; v.pc = p; v.instr = ins;
        v.e_state = es; v.e_count = ec; v.e_valid = ev; v.e_pc = ep; v.e_last = el; v.e_trig = et;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic a, ab, c, pp, input logic [31:0] p, ins);
        arm = a; abort = ab; cv = c; pop = pp; pc = p; instr = ins;
        @(posedge clk);
        #1;
        arm = 0; abort = 0; cv = 0; pop = 0;
    endtask

    initial begin
        // Test 1: five non-matching commits, abort, drain oldest-first.
        add(1,0,0,0, 0, NOP, 2'd1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++)
            add(0,0,1,0, 32'h100 + 4*k, NOP, 2'd1, k+1, 0, 0, 0, 0);
        add(0,1,0,0, 0, NOP, 2'd3, 5, 1, 32'h100, 0, 0);
        add(0,0,0,1, 0, NOP, 2'd3, 4, 1, 32'h104, 0, 0);
        add(0,0,0,1, 0, NOP, 2'd3, 3, 1, 32'h108, 0, 0);
        add(0,0,0,1, 0, NOP, 2'd3, 2, 1, 32'h10c, 0, 0);
        add(0,0,0,1, 0, NOP, 2'd3, 1, 1, 32'h110, 1, 0);
        add(0,0,0,1, 0, NOP, 2'd3, 0, 0, 0, 0, 0);
        add(0,0,0,1, 0, NOP, 2'd3, 0, 0, 0, 0, 0);
        add(0,0,1,0, 32'h500, NOP, 2'd3, 0, 0, 0, 0, 0);
        // Test 4: DONE ignores commits; arm clears it.
        add(1,0,0,0, 0, NOP, 2'd1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++)
            add(0,0,1,0, 32'h300 + 4*k, NOP, 2'd1, k+1, 0, 0, 0, 0);
        add(0,1,0,0, 0, NOP, 2'd3, 3, 1, 32'h300, 0, 0);
        add(0,0,1,0, 32'h400, NOP, 2'd3, 3, 1, 32'h300, 0, 0);
        add(1,0,0,0, 0, NOP, 2'd1, 0, 0, 0, 0, 0);
        // arm+abort while ARMED: abort wins.
        add(1,1,0,0, 0, NOP, 2'd3, 0, 0, 0, 0, 0);
        // Commit alongside arm is not captured.
        add(1,0,1,0, 32'h900, NOP, 2'd1, 0, 0, 0, 0, 0);
        // Commit + trigger + abort together: entry kept, triggered, DONE.
        add(0,1,1,0, 32'h904, BEQ, 2'd3, 1, 1, 32'h904, 1, 1);

        #2;
        chk("reset_state", ifa.state_o, 0);
        chk("reset_count", ifa.count_o, 0);
        chk("reset_valid", ifa.rd_valid_o, 0);
        chk("reset_trig",  ifa.triggered_o, 0);
        chk("reset_pc",    ifa.rd_pc_o, 0);
        @(posedge clk); #1;
        reset = 0;
        men = 2'b01;

        foreach (vq[i]) begin
            step(vq[i].arm, vq[i].abort, vq[i].cv, vq[i].pop, vq[i].pc, vq[i].instr);
            chk($sformatf("v%0d_state", i), ifa.state_o, vq[i].e_state);
            chk($sformatf("v%0d_count", i), ifa.count_o, vq[i].e_count);
            chk($sformatf("v%0d_valid", i), ifa.rd_valid_o, vq[i].e_valid);
            chk($sformatf("v%0d_pc", i), ifa.rd_pc_o, vq[i].e_pc);
            chk($sformatf("v%0d_last", i), ifa.rd_last_o, vq[i].e_last);
            chk($sformatf("v%0d_trig", i), ifa.triggered_o, vq[i].e_trig);
            if (vq[i].e_valid)
                chk($sformatf("v%0d_instr", i), ifa.rd_instr_o, (vq[i].e_pc == 32'h904) ? BEQ : NOP);
        end

        // Test 2: trigger at k=15, two post commits, keep last 8 (k=10..17).
        step(1,0,0,0, 0, NOP);
        for (int k = 0; k < 20; k++) begin
            step(0,0,1,0, 32'h200 + 4*k, (k == 15) ? BEQ : NOP);
            if (k == 14) chk("t2_pretrig", ifa.triggered_o, 0);
            if (k == 15) begin chk("t2_trig", ifa.triggered_o, 1); chk("t2_post15", ifa.state_o, 2); end
            if (k == 16) chk("t2_post16", ifa.state_o, 2);
            if (k == 17) chk("t2_done17", ifa.state_o, 3);
        end
        chk("t2_count", ifa.count_o, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_pc%0d", i), ifa.rd_pc_o, 32'h228 + 4*i);
            chk($sformatf("t2_last%0d", i), ifa.rd_last_o, (i == 7));
            step(0,0,0,1, 0, NOP);
        end
        chk("t2_drained", ifa.rd_valid_o, 0);

        // Test 3: POST_TRIG=0, channel 1 on lui.
        men = 2'b10;
        step(1,0,0,0, 0, NOP);
        step(0,0,1,0, 32'h600, LUI);
        chk("t3_state", ifb.state_o, 3);
        chk("t3_count", ifb.count_o, 1);
        chk("t3_last",  ifb.rd_last_o, 1);
        chk("t3_pc",    ifb.rd_pc_o, 32'h600);
        chk("t3_instr", ifb.rd_instr_o, LUI);
        chk("t3_trig",  ifb.triggered_o, 1);

        // Test 5: async reset mid-POST takes effect without a clock edge.
        men = 2'b01;
        step(1,0,0,0, 0, NOP);
        step(0,0,1,0, 32'h700, BEQ);
        step(0,0,1,0, 32'h704, NOP);
        chk("t5_post", ifa.state_o, 2);
        chk("t5_cnt2", ifa.count_o, 2);
        #2 reset = 1;
        #1;
        chk("t5_rst_state", ifa.state_o, 0);
        chk("t5_rst_count", ifa.count_o, 0);
        chk("t5_rst_trig",  ifa.triggered_o, 0);
        chk("t5_rst_valid", ifa.rd_valid_o, 0);
        chk("t5_rst_pc",    ifa.rd_pc_o, 0);
        @(posedge clk); #1;
        reset = 0;

`ifdef HFRV_TRACE_TSTAMP_EN
        // Test 6: 4-bit timestamps at cycles 3, 7 and 19 (wraps to 3).
        men = 2'b00;
        step(1,0,0,0, 0, NOP);
        repeat (3) step(0,0,0,0, 0, NOP);
        step(0,0,1,0, 32'h800, NOP);
        repeat (3) step(0,0,0,0, 0, NOP);
        step(0,0,1,0, 32'h804, NOP);
        repeat (11) step(0,0,0,0, 0, NOP);
        step(0,0,1,0, 32'h808, NOP);
        step(0,1,0,0, 0, NOP);
        chk("t6_ts0", ifa.rd_tstamp_o, 3);
        step(0,0,0,1, 0, NOP);
        chk("t6_ts1", ifa.rd_tstamp_o, 7);
        step(0,0,0,1, 0, NOP);
        chk("t6_ts2", ifa.rd_tstamp_o, 3);
        chk("t6_pc2", ifa.rd_pc_o, 32'h808);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
